// File: rtl/alarm_timer.sv
// alarm_timer: mm:ss countdown / count-up timer with a settable preset and a
// timed alarm phase.
//
// The preset is edited in SET with single-second increments. A rising edge
// on run starts counting from the preset (down) or from 00:00 (up). Dropping
// run pauses the count, and a new rising edge resumes it. When the count
// reaches its terminal value, alarm stays high for ALARM_TICKS one-second
// ticks, after which the count is reloaded.
//
// Build option:
//   ALARM_TIMER_AUTORELOAD_EN
//     Defined:   if run is still high when the alarm ends, counting restarts
//                (periodic timer).
//     Undefined: the timer always returns to IDLE after the alarm.
//
// Parameters:
//   TICK_DIV     clk cycles per one-second tick (2..2^26)
//   MAX_MIN      highest minutes value (1..99)
//   ALARM_TICKS  ticks that alarm stays high (1..255)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   run       level input; a rising edge starts or resumes, low pauses
//   clear     one-cycle pulse; aborts the run and reloads the count
//   set_mode  level input; enables preset editing
//   inc       one-cycle pulse; adds one second to the preset while in SET
//   count_up  direction, sampled on IDLE->RUN (0 = down, 1 = up)
//   bin0..3   BCD digits: sec units, sec tens, min units, min tens
//   state_o   IDLE=0 SET=1 RUN=2 PAUSE=3 ALARM=4
//   alarm     high for the whole ALARM state

module alarm_timer #(
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_MIN     = 59,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    input  logic       set_mode,
    input  logic       inc,
    input  logic       count_up,
    output logic [3:0] bin0,
    output logic [3:0] bin1,
    output logic [3:0] bin2,
    output logic [3:0] bin3,
    output logic [2:0] state_o,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        ALARM = 3'd4
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [7:0]    ALARM_LAST = 8'(ALARM_TICKS - 1);
    localparam logic [3:0]    MAX_M10    = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_M1     = 4'(MAX_MIN % 10);
    localparam logic [15:0]   MAX_TIME   = {MAX_M10, MAX_M1, 4'd5, 4'd9};

    // Times are packed as {min tens, min units, sec tens, sec units} BCD.
    // One second forward, wrapping MAX_MIN:59 to 00:00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] s1, s10, m1, m10;
        {m10, m1, s10, s1} = t;
        if (t == MAX_TIME) begin
            return 16'h0000;
        end
        if (s1 != 4'd9) begin
            s1 = s1 + 4'd1;
        end else begin
            s1 = 4'd0;
            if (s10 != 4'd5) begin
                s10 = s10 + 4'd1;
            end else begin
                s10 = 4'd0;
                if (m1 != 4'd9) begin
                    m1 = m1 + 4'd1;
                end else begin
                    m1  = 4'd0;
                    m10 = m10 + 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    // One second backward, wrapping 00:00 to MAX_MIN:59.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] s1, s10, m1, m10;
        {m10, m1, s10, s1} = t;
        if (t == 16'h0000) begin
            return MAX_TIME;
        end
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    state_t         state, state_n;
    logic [15:0]    preset, preset_n;
    logic [15:0]    count, count_n;
    logic [TW-1:0]  tick_cnt, tick_n;
    logic [7:0]     alarm_cnt, alarm_cnt_n;
    logic           dir, dir_n;
    logic           run_q;
    logic           run_armed;

    logic           run_rise;
    logic           tick;
    logic           counting;
    logic [15:0]    inc_preset;
    logic [15:0]    stepped_count;
    logic [15:0]    terminal;
    logic [15:0]    reload_latched;
    logic [15:0]    display;

    // run_armed suppresses a false start edge on the first cycle after
    // reset, while run_q is still catching up with a run held high.
    assign run_rise       = run_armed & run & ~run_q;
    assign counting       = (state == RUN) || (state == ALARM);
    assign tick           = counting && (tick_cnt == TICK_LAST);
    assign inc_preset     = bcd_inc(preset);
    assign stepped_count  = dir ? bcd_inc(count) : bcd_dec(count);
    assign terminal       = dir ? preset : 16'h0000;
    assign reload_latched = dir ? 16'h0000 : preset;

    // Register bank for the FSM and its datapath. Reset puts everything,
    // including the run edge detector and the latched direction, back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            preset    <= '0;
            count     <= '0;
            tick_cnt  <= '0;
            alarm_cnt <= '0;
            dir       <= 1'b0;
            run_q     <= 1'b0;
            run_armed <= 1'b0;
        end else begin
            state     <= state_n;
            preset    <= preset_n;
            count     <= count_n;
            tick_cnt  <= tick_n;
            alarm_cnt <= alarm_cnt_n;
            dir       <= dir_n;
            run_q     <= run;
            run_armed <= 1'b1;
        end
    end

    // Next-state and datapath logic. The tick divider free-runs in RUN and
    // ALARM, holds its value in PAUSE so that a resumed second is not
    // restarted, and sits at 0 in IDLE and SET. clear takes priority over
    // every other input. In RUN the tick is applied before a pause request
    // in the same cycle, so no second is lost.
    always_comb begin
        state_n     = state;
        preset_n    = preset;
        count_n     = count;
        tick_n      = tick_cnt;
        alarm_cnt_n = alarm_cnt;
        dir_n       = dir;

        if (counting) begin
            tick_n = tick ? '0 : tick_cnt + 1'b1;
        end else if (state != PAUSE) begin
            tick_n = '0;
        end

        if (clear) begin
            if (state == RUN || state == PAUSE || state == ALARM) begin
                state_n     = IDLE;
                count_n     = reload_latched;
                tick_n      = '0;
                alarm_cnt_n = '0;
            end else begin
                count_n = count_up ? 16'h0000 : preset;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (set_mode) begin
                        state_n = SET;
                    end else if (run_rise && preset != 16'h0000) begin
                        state_n = RUN;
                        dir_n   = count_up;
                        count_n = count_up ? 16'h0000 : preset;
                        tick_n  = '0;
                    end
                end
                SET: begin
                    preset_n = inc ? inc_preset : preset;
                    if (!set_mode) begin
                        state_n = IDLE;
                        count_n = count_up ? 16'h0000 : preset_n;
                    end
                end
                RUN: begin
                    if (tick) begin
                        count_n = stepped_count;
                    end
                    if (tick && stepped_count == terminal) begin
                        state_n     = ALARM;
                        alarm_cnt_n = '0;
                    end else if (!run) begin
                        state_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (run_rise) begin
                        state_n = RUN;
                    end
                end
                ALARM: begin
                    if (tick) begin
                        if (alarm_cnt == ALARM_LAST) begin
                            count_n     = reload_latched;
                            alarm_cnt_n = '0;
                            tick_n      = '0;
`ifdef ALARM_TIMER_AUTORELOAD_EN
                            state_n = run ? RUN : IDLE;
`else
                            state_n = IDLE;
`endif
                        end else begin
                            alarm_cnt_n = alarm_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // The display shows the preset being edited in SET, otherwise the count.
    assign display = (state == SET) ? preset : count;
    assign bin0    = display[3:0];
    assign bin1    = display[7:4];
    assign bin2    = display[11:8];
    assign bin3    = display[15:12];
    assign state_o = state;
    assign alarm   = (state == ALARM);

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (legal 2..2^26).
REQ-002 Parameter MAX_MIN, default 59, highest minutes value (legal 1..99).
REQ-003 Parameter ALARM_TICKS, default 10, ticks alarm stays asserted (legal 1..255).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; internal rising edge = start/resume, low level in RUN = pause.
REQ-007 clear  input  1  single-cycle pulse; abort and reload count from preset.
REQ-008 set_mode  input  1  level; preset edit enable.
REQ-009 inc  input  1  single-cycle pulse, already debounced; preset +1 second.
REQ-010 count_up  input  1  direction, sampled only on IDLE->RUN; 0 = down to 00:00, 1 = up from 00:00 to preset.
REQ-011 bin0, bin1, bin2, bin3  output  4 each  BCD digits sec-units, sec-tens, min-units, min-tens.
REQ-012 state_o  output  3  current state encoding (IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4).
REQ-013 alarm  output  1  high throughout ALARM state.

Function
REQ-014 States IDLE, SET, RUN, PAUSE, ALARM; single registered FSM; priority reset > clear > all else.
REQ-015 IDLE->SET when set_mode=1; SET->IDLE when set_mode=0, loading count from preset (down) or 00:00 (up) in the same cycle.
REQ-016 In SET, each inc adds one second to preset: sec-units 9->0 carry, sec-tens 5->0 carry, minutes BCD carry, MAX_MIN:59 -> 00:00.
REQ-017 Outputs show preset in SET, count in every other state.
REQ-018 IDLE->RUN on run rising edge with set_mode=0 and preset != 00:00; preset 00:00 leaves FSM in IDLE; direction latched here; tick counter cleared.
REQ-019 Tick counter increments every clk in RUN and ALARM, wraps at TICK_DIV-1, emits one-cycle tick at wrap; frozen (value retained) in IDLE-exit-excluded PAUSE, cleared in IDLE and SET.
REQ-020 RUN: each tick decrements (down) or increments (up) count by one second in BCD, borrows/carries per REQ-016 limits.
REQ-021 RUN->ALARM on the tick that makes count equal terminal (00:00 down, preset up); count holds terminal.
REQ-022 RUN->PAUSE when run=0; PAUSE->RUN on run rising edge, resuming with retained tick counter and count.
REQ-023 ALARM lasts exactly ALARM_TICKS ticks, then count reloads per REQ-015 and FSM exits per REQ-031.
REQ-024 clear in RUN, PAUSE or ALARM: next cycle state IDLE, count reloaded, alarm=0, tick counter 0; clear in IDLE/SET reloads count only.
REQ-025 inc outside SET ignored; set_mode outside IDLE/SET ignored; inc and set_mode falling in same cycle: increment applied, then reload uses incremented preset.
REQ-026 Preset changes never alter a count already loaded in RUN/PAUSE.

Reset
REQ-027 reset=1 at a clk edge: state IDLE, preset 00:00, count 00:00, tick counter 0, alarm 0, run edge register 0, direction 0.
REQ-028 Reset mid-RUN or mid-ALARM takes effect next edge with no partial update; run held high through reset release does not start (edge register reset to 0, needs fresh rising edge... register loads run on first post-reset cycle without generating an edge).

Configuration
REQ-029 Macro ALARM_TIMER_AUTORELOAD_EN selects end-of-alarm behaviour.
REQ-030 Defined: after ALARM, if run=1 FSM re-enters RUN with reloaded count and cleared tick counter (periodic timer); if run=0 goes IDLE.
REQ-031 Undefined: after ALARM FSM always goes IDLE; restart requires a new run rising edge.

Verification (TICK_DIV=4, MAX_MIN=59, ALARM_TICKS=2)
REQ-032 reset; set_mode=1; 75 inc pulses; set_mode=0 -> bin3..0 = 0,1,1,5; state IDLE.
REQ-033 preset 00:03, count_up=0, run rise -> digits 00:02,00:01,00:00 at 4-cycle spacing; alarm high 8 cycles; then 00:03, IDLE (macro undefined).
REQ-034 preset 59:59, one inc in SET -> 00:00; run rise -> stays IDLE.
REQ-035 preset 01:00 down, run, after 1 tick run=0 for 20 cycles -> 00:59 held, PAUSE; run rise -> next 00:58 after remaining tick cycles.
REQ-036 preset 00:02, count_up=1 -> 00:01, 00:02, ALARM; clear during ALARM -> next cycle IDLE, alarm=0, count 00:00.
REQ-037 macro defined, preset 00:01, run held 1 -> alarm pulses repeat every 3 ticks (1 run + 2 alarm); reset mid-RUN -> all outputs 0, IDLE.
